// File: rtl/Isa.sv
// Shared ISA definitions: register width, multiplier packet layout and the
// SPI master state encoding used by the processor-side multiplier link.
package Isa;

  localparam int REGISTER_SIZE = 8;

  // Serial packet sent to the multiplier: op_1 goes out first (low half).
  typedef struct packed {
    logic [REGISTER_SIZE-1:0] op_2;
    logic [REGISTER_SIZE-1:0] op_1;
  } MulPacket;

  typedef enum logic [2:0] {
    IDLE,
    START,
    TX,
    AWAIT,
    RX,
    DONE
  } mul_master_state_t;

endpackage

// File: rtl/bit_serializer.sv
// Parallel-load, LSB-first shift register with a bit counter and a last-bit
// flag. Shifts right, new bits enter at the MSB, outgoing bit is data[0].
module bit_serializer #(
  parameter int WIDTH = 8
) (
  input  logic             i_clock,
  input  logic             i_reset,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_load_data,
  input  logic             i_shift,
  input  logic             i_serial_in,
  output logic [WIDTH-1:0] o_data,
  output logic             o_last
);

  localparam int CntWidth = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic [WIDTH-1:0]    data_q;
  logic [CntWidth-1:0] cnt_q;

  // Only the counter is reset; the data is always loaded before use.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      cnt_q <= '0;
    end else if (i_load) begin
      cnt_q <= '0;
    end else if (i_shift) begin
      cnt_q <= cnt_q + CntWidth'(1);
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_load) begin
      data_q <= i_load_data;
    end else if (i_shift) begin
      data_q <= {i_serial_in, data_q[WIDTH-1:1]};
    end
  end

  assign o_data = data_q;
  assign o_last = (cnt_q == CntWidth'(WIDTH - 1));

endmodule

// File: rtl/mul_spi_master.sv
// SPI master for the serial multiplier: frames a start bit plus MulPacket on
// MOSI, waits for the slave ready marker, deserialises the product from MISO.
// Optional AWAIT timeout: define MUL_MASTER_TIMEOUT_EN.
module mul_spi_master
  import Isa::*;
#(
  parameter int SlaveCount    = 1,
  parameter int TimeoutCycles = 64,
  localparam int SelWidth     = (SlaveCount > 1) ? $clog2(SlaveCount) : 1
) (
  input  logic                     i_clock,
  input  logic                     i_reset,
  input  logic                     i_valid,
  output logic                     o_ready,
  input  logic [REGISTER_SIZE-1:0] i_op_1,
  input  logic [REGISTER_SIZE-1:0] i_op_2,
  input  logic [SelWidth-1:0]      i_slave_sel,
  output logic [REGISTER_SIZE-1:0] o_result,
  output logic                     o_result_valid,
  output logic                     o_error,
  output logic [SlaveCount-1:0]    o_nss,
  output logic                     o_mosi,
  input  logic                     i_miso
);

  localparam int W  = REGISTER_SIZE;
  localparam int PW = 2 * REGISTER_SIZE;

  mul_master_state_t state_q, state_d;

  MulPacket              packet;
  logic [SelWidth-1:0]   sel_q;
  logic                  sel_ok;
  logic                  accept;
  logic [SlaveCount-1:0] nss_sel;

  logic [PW-1:0]         tx_word;
  logic [PW-2:0]         tx_upper_unused;
  logic                  tx_last;
  logic [W-1:0]          rx_word;
  logic                  rx_lsb_unused;
  logic                  rx_last;
  logic                  rx_start;

  logic [W-1:0]          result_q;
  logic                  timeout;

  assign accept      = (state_q == IDLE) && i_valid;
  assign packet.op_1 = i_op_1;
  assign packet.op_2 = i_op_2;
  assign sel_ok      = int'(sel_q) < SlaveCount;
  // An out-of-range index shifts the one-hot bit away, leaving all NSS high.
  assign nss_sel     = ~(SlaveCount'(1) << sel_q);
  assign rx_start    = (state_q == AWAIT) && sel_ok && i_miso;

  always_ff @(posedge i_clock) begin
    if (accept) begin
      sel_q <= i_slave_sel;
    end
  end

  bit_serializer #(.WIDTH(PW)) u_tx (
    .i_clock     (i_clock),
    .i_reset     (i_reset),
    .i_load      (accept),
    .i_load_data (packet),
    .i_shift     (state_q == TX),
    .i_serial_in (1'b0),
    .o_data      (tx_word),
    .o_last      (tx_last)
  );

  bit_serializer #(.WIDTH(W)) u_rx (
    .i_clock     (i_clock),
    .i_reset     (i_reset),
    .i_load      (rx_start),
    .i_load_data ('0),
    .i_shift     (state_q == RX),
    .i_serial_in (i_miso),
    .o_data      (rx_word),
    .o_last      (rx_last)
  );

  assign tx_upper_unused = tx_word[PW-1:1];
  assign rx_lsb_unused   = rx_word[0];

`ifdef MUL_MASTER_TIMEOUT_EN
  localparam int WaitWidth = $clog2(TimeoutCycles + 1);

  logic [WaitWidth-1:0] wait_q;
  logic                 error_q;

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      wait_q <= '0;
    end else if (state_q == AWAIT) begin
      wait_q <= wait_q + WaitWidth'(1);
    end else begin
      wait_q <= '0;
    end
  end

  assign timeout = (state_q == AWAIT) && (wait_q == WaitWidth'(TimeoutCycles - 1));

  // Any AWAIT -> DONE exit is an abnormal end (bad select or starved slave).
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      error_q <= 1'b0;
    end else if ((state_q == AWAIT) && (state_d == DONE)) begin
      error_q <= 1'b1;
    end else if ((state_q == RX) && (state_d == DONE)) begin
      error_q <= 1'b0;
    end
  end

  assign o_error = error_q;
`else
  localparam int timeout_cycles_unused = TimeoutCycles;

  assign timeout = 1'b0;
  assign o_error = 1'b0;
`endif

  // The final MISO bit is folded in here so o_result is ready during DONE.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      result_q <= '0;
    end else if ((state_q == RX) && rx_last) begin
      result_q <= {i_miso, rx_word[W-1:1]};
    end else if ((state_q == AWAIT) && !sel_ok) begin
      result_q <= '0;
    end
  end

  assign o_result = result_q;

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (i_valid) state_d = START;
      START:   state_d = TX;
      TX:      if (tx_last) state_d = AWAIT;
      AWAIT: begin
        if (!sel_ok)      state_d = DONE;
        else if (i_miso)  state_d = RX;
        else if (timeout) state_d = DONE;
      end
      RX:      if (rx_last) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    o_ready        = 1'b0;
    o_nss          = '1;
    o_mosi         = 1'b0;
    o_result_valid = 1'b0;
    case (state_q)
      IDLE:  o_ready = 1'b1;
      START: begin
        o_nss  = nss_sel;
        o_mosi = 1'b1;
      end
      TX: begin
        o_nss  = nss_sel;
        o_mosi = tx_word[0];
      end
      AWAIT, RX: o_nss = nss_sel;
      DONE:  o_result_valid = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mul_spi_master.sv
// Scoreboard bench for mul_spi_master against a behavioural multiplier slave.
module tb_mul_spi_master;
  import Isa::*;

  localparam int W  = REGISTER_SIZE;
  localparam int NS = 3;
  localparam int TO = 16;
`ifdef MUL_MASTER_TIMEOUT_EN
  localparam bit TIMEOUT_EN = 1'b1;
`else
  localparam bit TIMEOUT_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          valid;
  logic          ready;
  logic [W-1:0]  op1, op2, result;
  logic [1:0]    sel;
  logic          res_valid, err;
  logic [NS-1:0] nss;
  logic          mosi, miso;

  mul_spi_master #(.SlaveCount(NS), .TimeoutCycles(TO)) dut (
    .i_clock        (clk),
    .i_reset        (rst),
    .i_valid        (valid),
    .o_ready        (ready),
    .i_op_1         (op1),
    .i_op_2         (op2),
    .i_slave_sel    (sel),
    .o_result       (result),
    .o_result_valid (res_valid),
    .o_error        (err),
    .o_nss          (nss),
    .o_mosi         (mosi),
    .i_miso         (miso)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [W-1:0] res;
    logic         err;
    int           lat;
    int           low;
    int           acc;
  } exp_t;

  exp_t          sbq[$];
  int            checks = 0;
  int            passes = 0;
  logic [W-1:0]  held = '0;
  logic [NS-1:0] exp_mask = '1;
  int            low_cnt = 0;
  logic          bad_nss = 1'b0;
  bit            mute = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Expected outcome from the request alone: product mod 2^W, frame lengths.
  task automatic push_exp(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [1:0] s, input bit starve);
    exp_t e;
    if (starve) begin
      e.res = held; e.err = 1'b1; e.lat = 2*W + 2 + TO; e.low = 2*W + 1 + TO;
      exp_mask = ~(NS'(1) << s);
    end else if (int'(s) < NS) begin
      e.res = W'(int'(a) * int'(b)); e.err = 1'b0; e.lat = 3*W + 4; e.low = 3*W + 3;
      exp_mask = ~(NS'(1) << s);
      held = e.res;
    end else begin
      e.res = '0; e.err = TIMEOUT_EN; e.lat = 2*W + 3; e.low = 0;
      exp_mask = '1;
      held = '0;
    end
    e.acc   = cyc;
    low_cnt = 0;
    bad_nss = 1'b0;
    sbq.push_back(e);
  endtask

  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [1:0] s, input bit starve);
    int w = 0;
    @(negedge clk);
    while (!ready && w < 300) begin
      @(negedge clk);
      w++;
    end
    if (!ready) begin
      checks++;
      $display("FAIL ready_wait: got 0 expected 1 (cycle %0d)", cyc);
    end else begin
      op1 = a; op2 = b; sel = s; valid = 1'b1;
      push_exp(a, b, s, starve);
      @(negedge clk);
      valid = 1'b0;
    end
  endtask

  task automatic drain();
    int w = 0;
    while (sbq.size() != 0 && w < 400) begin
      @(negedge clk);
      w++;
    end
    if (sbq.size() != 0) begin
      checks++;
      $display("FAIL drain: got %0d pending expected 0", sbq.size());
      sbq.delete();
    end
    @(negedge clk);
  endtask

  // Behavioural slave: start bit, 2W packet bits, OPERATE, ready marker, product.
  initial begin
    int            sn;
    logic          sstart;
    logic [2*W-1:0] spkt;
    logic [W-1:0]  sprod;
    logic          nxt;
    sn = 0; sstart = 1'b0; spkt = '0; sprod = '0;
    miso = 1'b0;
    forever begin
      @(negedge clk);
      nxt = 1'b0;
      if (nss != '1) begin
        sn++;
        low_cnt++;
        if (nss != exp_mask) bad_nss = 1'b1;
        if (sn == 1) sstart = mosi;
        else if (sn <= 2*W + 1) spkt[sn-2] = mosi;
        if (sn == 2*W + 1) sprod = W'(int'(spkt[W-1:0]) * int'(spkt[2*W-1:W]));
        if (mute || !sstart) nxt = 1'b0;
        else if (sn == 2*W + 2) nxt = 1'b1;
        else if (sn >= 2*W + 3 && sn < 3*W + 3) nxt = sprod[sn-(2*W+3)];
      end else begin
        sn  = 0;
        nxt = 1'($urandom_range(0, 1));
      end
      @(posedge clk);
      #1 miso = nxt;
    end
  end

  // Monitor: pops one expectation per result strobe.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (res_valid) begin
        if (sbq.size() == 0) begin
          chk("unexpected_result", 0, 1);
        end else begin
          e = sbq.pop_front();
          chk("result", result, e.res);
          chk("error", err, e.err);
          chk("latency", cyc - e.acc, e.lat);
          chk("nss_low_cycles", low_cnt, e.low);
          chk("nss_wrong_line", bad_nss, 0);
        end
      end else if (sbq.size() > 0 && (cyc - sbq[0].acc) > 100) begin
        checks++;
        $display("FAIL result_timeout: got none expected strobe by cycle %0d", sbq[0].acc + sbq[0].lat);
        void'(sbq.pop_front());
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int prev_acc;
    int n_acc;
    int w;
    logic [1:0] s;
    rst = 1'b1; valid = 1'b0; op1 = '0; op2 = '0; sel = '0;
    repeat (3) @(negedge clk);
    chk("reset_ready", ready, 1);
    chk("reset_nss", nss, {NS{1'b1}});
    chk("reset_mosi", mosi, 0);
    chk("reset_result", result, 0);
    chk("reset_valid", res_valid, 0);
    chk("reset_error", err, 0);
    rst = 1'b0;

    issue(8'd3, 8'd5, 2'd0, 1'b0);
    issue(8'hFF, 8'h02, 2'd1, 1'b0);
    issue(8'd7, 8'd9, 2'd3, 1'b0);
    issue(8'd11, 8'd13, 2'd2, 1'b0);
    drain();

    for (int i = 0; i < 10; i++) begin
      s = 2'($urandom_range(0, 3));
      issue(W'($urandom), W'($urandom), s, 1'b0);
    end
    drain();

    // i_valid held high: operands change every cycle, accepts only in IDLE.
    n_acc = 0; prev_acc = 0; w = 0;
    while (n_acc < 4 && w < 300) begin
      @(negedge clk);
      w++;
      op1 = W'($urandom); op2 = W'($urandom); sel = 2'($urandom_range(0, 2));
      valid = 1'b1;
      if (ready) begin
        if (n_acc > 0) chk("b2b_interval", cyc - prev_acc, 3*W + 5);
        prev_acc = cyc;
        push_exp(op1, op2, sel, 1'b0);
        n_acc++;
      end
    end
    chk("b2b_accepts", n_acc, 4);
    drain();
    valid = 1'b0;
    drain();

    // Reset in the middle of TX.
    issue(8'h5A, 8'hC3, 2'd1, 1'b0);
    repeat (10) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("midreset_nss", nss, {NS{1'b1}});
    chk("midreset_mosi", mosi, 0);
    chk("midreset_ready", ready, 1);
    chk("midreset_result", result, 0);
    sbq.delete();
    held = '0;
    rst = 1'b0;
    issue(8'd12, 8'd10, 2'd1, 1'b0);
    drain();

`ifdef MUL_MASTER_TIMEOUT_EN
    mute = 1'b1;
    issue(8'd2, 8'd2, 2'd0, 1'b1);
    drain();
    mute = 1'b0;
    issue(8'd6, 8'd7, 2'd2, 1'b0);
    drain();
`endif

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
